chip8_uart_tx: RTL and testbench



---
 rtl/chip8_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_chip8_uart_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_uart_tx.sv
// chip8_uart_tx: 8N1 UART transmitter (LSB first) fed by a small byte FIFO.
// Bytes enter through a valid/ready push port and are serialised onto an
// idle-high line. Frames from queued bytes follow each other with no gap.
//
// Handshake: a byte on tx_d is taken on any rising edge where tx_v and
// tx_ready are both high (and resetn is high). tx_ready depends only on the
// FIFO fill level, never on tx_v. Holding tx_v while tx_ready is low does
// nothing. The producer may change tx_d or drop tx_v at any time.
module chip8_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_d,
  input  logic       tx_v,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C   = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
  localparam logic [15:0]        BAUD_LAST = CLKS_PER_BIT[15:0] - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               line_q, line_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic push;
  logic pop;
  logic baud_done;
  logic fifo_nonempty;

  assign tx_ready      = (count_q != DEPTH_C);
  assign push          = tx_v & tx_ready;
  assign fifo_nonempty = (count_q != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  assign busy          = (state_q != S_IDLE) | fifo_nonempty;
  assign tx            = line_q;

  // Serialiser next state: pops the FIFO head at frame start and walks the
  // start, data and stop bits, each lasting CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    line_d  = line_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          line_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          line_d  = sh_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            line_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            // Line already shows sh[0]; next bit is sh[1] before the shift.
            sh_d   = {1'b0, sh_q[7:1]};
            line_d = sh_q[1];
            bit_d  = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            line_d  = 1'b0;
            state_d = S_START;
          end else begin
            line_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and fill-level next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; not reset since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (resetn && push) mem_q[wr_ptr_q] <= tx_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      line_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      line_q   <= line_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_chip8_uart_tx.sv
// Directed bench for chip8_uart_tx: three instances cover the default
// 4-cycle-bit setup, a shallow FIFO for backpressure and the 2-cycle minimum.
module tb_chip8_uart_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn_a  = 1'b0;
  logic resetn_bc = 1'b0;

  // ---------------- shared stimulus, routed by sel ----------------
  int         sel  = 0;
  logic [7:0] tx_d = 8'h00;
  logic       tx_v = 1'b0;

  logic tx_v_a, tx_v_b, tx_v_c;
  logic tx_ready_a, tx_a, busy_a;
  logic tx_ready_b, tx_b, busy_b;
  logic tx_ready_c, tx_c, busy_c;
  logic tx_s, busy_s, ready_s;

  assign tx_v_a  = tx_v & (sel == 0);
  assign tx_v_b  = tx_v & (sel == 1);
  assign tx_v_c  = tx_v & (sel == 2);
  assign tx_s    = (sel == 0) ? tx_a       : (sel == 1) ? tx_b       : tx_c;
  assign busy_s  = (sel == 0) ? busy_a     : (sel == 1) ? busy_b     : busy_c;
  assign ready_s = (sel == 0) ? tx_ready_a : (sel == 1) ? tx_ready_b : tx_ready_c;

  chip8_uart_tx #(.CLKS_PER_BIT(4), .FIFO_AW(3)) dut_a (
    .clk(clk), .resetn(resetn_a), .tx_d(tx_d), .tx_v(tx_v_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a)
  );

  chip8_uart_tx #(.CLKS_PER_BIT(8), .FIFO_AW(2)) dut_b (
    .clk(clk), .resetn(resetn_bc), .tx_d(tx_d), .tx_v(tx_v_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
  );

  chip8_uart_tx #(.CLKS_PER_BIT(2), .FIFO_AW(3)) dut_c (
    .clk(clk), .resetn(resetn_bc), .tx_d(tx_d), .tx_v(tx_v_c),
    .tx_ready(tx_ready_c), .tx(tx_c), .busy(busy_c)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int f);
    if (f == 0) return 1'b0;
    if (f == 9) return 1'b1;
    return b[f-1];
  endfunction

  // Called on the negedge after the first start-bit edge; checks every
  // cycle of every queued frame, then leaves us one negedge past the end.
  task automatic expect_stream(input int c);
    logic [7:0] b;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int f = 0; f < 10; f++) begin
        for (int j = 0; j < c; j++) begin
          check($sformatf("dut%0d_byte%02h_bit%0d_cyc%0d", sel, b, f, j), tx_s, frame_bit(b, f));
          @(negedge clk);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drv(input logic [7:0] d);
    tx_d = d;
    tx_v = 1'b1;
    @(negedge clk);
  endtask

  // start, A5 LSB first, stop
  int a5_tbl[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    // ---- reset, with tx_v high to show it is ignored ----
    sel  = 0;
    tx_d = 8'h55;
    tx_v = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_ready_a", tx_ready_a, 1);
    check("rst_tx_b", tx_b, 1);
    check("rst_busy_b", busy_b, 0);
    check("rst_ready_b", tx_ready_b, 1);
    check("rst_tx_c", tx_c, 1);
    check("rst_busy_c", busy_c, 0);
    tx_v      = 1'b0;
    resetn_a  = 1'b1;
    resetn_bc = 1'b1;
    @(negedge clk);
    check("post_rst_busy_a", busy_a, 0);
    check("post_rst_tx_a", tx_a, 1);

    // ---- single byte A5, CLKS_PER_BIT=4 ----
    sel = 0;
    drv(8'hA5);
    tx_v = 1'b0;
    check("a5_lat_tx_idle", tx_s, 1);
    check("a5_lat_busy", busy_s, 1);
    for (int f = 0; f < 10; f++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("a5_bit%0d_cyc%0d", f, j), tx_s, a5_tbl[f]);
      end
    end
    check("a5_busy_k40", busy_s, 1);
    @(negedge clk);
    check("a5_busy_k41", busy_s, 0);
    check("a5_tx_k41", tx_s, 1);
    repeat (3) @(negedge clk);

    // ---- back-to-back 00 FF 3C ----
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    fork
      begin
        drv(8'h00); drv(8'hFF); drv(8'h3C);
        tx_v = 1'b0;
      end
      begin
        @(negedge clk);
        check("b2b_lat_tx", tx_s, 1);
        @(negedge clk);
        expect_stream(4);
      end
    join
    check("b2b_busy_end", busy_s, 0);
    check("b2b_tx_end", tx_s, 1);
    repeat (3) @(negedge clk);

    // ---- backpressure: FIFO depth 4, tx_v high 12 cycles ----
    sel   = 1;
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          tx_d = 8'h10 + 8'(i);
          tx_v = 1'b1;
          @(negedge clk);
          check($sformatf("bp_ready_%0d", i), ready_s, (i < 4) ? 1 : 0);
        end
        tx_v = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        expect_stream(8);
      end
    join
    check("bp_busy_end", busy_s, 0);
    repeat (3) @(negedge clk);

    // ---- push held through the STOP->START pop while full ----
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0};
    fork
      begin
        for (int i = 0; i < 83; i++) begin
          tx_d = (i < 5) ? (8'hA0 + 8'(i)) : 8'hB0;
          tx_v = 1'b1;
          @(negedge clk);
          if (i == 4)  check("full_ready_k4", ready_s, 0);
          if (i == 80) check("full_ready_k80", ready_s, 0);
          if (i == 81) check("full_ready_k81", ready_s, 1);
          if (i == 82) check("full_ready_k82", ready_s, 0);
        end
        tx_v = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        expect_stream(8);
      end
    join
    check("full_busy_end", busy_s, 0);
    repeat (3) @(negedge clk);

    // ---- reset during DATA bit 3 of 5A with two bytes queued ----
    sel = 0;
    drv(8'h5A); drv(8'h11); drv(8'h22);
    tx_v = 1'b0;
    repeat (14) @(negedge clk);
    check("rmf_bit2", tx_s, 0);
    @(negedge clk);
    check("rmf_bit3", tx_s, 1);
    check("rmf_busy_pre", busy_s, 1);
    resetn_a = 1'b0;
    @(negedge clk);
    check("rmf_tx", tx_s, 1);
    check("rmf_busy", busy_s, 0);
    check("rmf_ready", ready_s, 1);
    resetn_a = 1'b1;
    @(negedge clk);
    check("rmf_idle_busy", busy_s, 0);
    exp_q = '{8'h81};
    fork
      begin
        drv(8'h81);
        tx_v = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        expect_stream(4);
      end
    join
    check("rmf_busy_end", busy_s, 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("rmf_quiet_%0d", i), tx_s, 1);
      @(negedge clk);
    end

    // ---- minimum baud, CLKS_PER_BIT=2 ----
    sel   = 2;
    exp_q = '{8'hFF, 8'h00};
    fork
      begin
        drv(8'hFF); drv(8'h00);
        tx_v = 1'b0;
      end
      begin
        @(negedge clk);
        check("minb_lat_tx", tx_s, 1);
        @(negedge clk);
        expect_stream(2);
      end
    join
    check("minb_busy_end", busy_s, 0);
    check("minb_tx_end", tx_s, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
